tag_ct_coalescer: RTL and testbench

//  Sits directly downstream of the spike generator array's TagCtChannel output, upstream of the tag router.

---
 rtl/tag_ct_coalescer.sv | 123 ++++++++++++
 tb/tb_tag_ct_coalescer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ct_coalescer.sv
// Tag/count coalescer between the spike generator array and the tag router.
// Merges back-to-back same-tag events into one summed event and flushes on unit_pulse.
module tag_ct_coalescer #(
    parameter int Ntag    = 11,
    parameter int Nct     = 10,
    parameter int MaxHold = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            unit_pulse,
    input  logic            coalesce_en,
    input  logic            in_v,
    input  logic [Ntag-1:0] in_tag,
    input  logic [Nct-1:0]  in_ct,
    output logic            in_a,
    output logic            out_v,
    output logic [Ntag-1:0] out_tag,
    output logic [Nct-1:0]  out_ct,
    input  logic            out_a
);
    localparam int            HW        = $clog2(MaxHold);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MaxHold - 1);
    localparam logic [Nct:0]  CT_MAX    = {1'b0, {Nct{1'b1}}};

    typedef enum logic [1:0] {EMPTY, ACCUM, FLUSH} state_t;

    state_t          state, state_d;
    logic [Ntag-1:0] p_tag, p_tag_d;
    logic [Nct-1:0]  p_ct, p_ct_d;
    logic [HW-1:0]   hold_ctr, hold_d;
    logic [Nct:0]    sum;
    logic            o_free, merge, accept, load_o;

    assign o_free = !out_v || out_a;
    // One extra bit on the sum so an overflowing merge is refused instead of wrapping.
    assign sum    = {1'b0, p_ct} + {1'b0, in_ct};
    assign merge  = coalesce_en && (state != EMPTY) && (in_tag == p_tag) && (sum <= CT_MAX);

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d = state;
        p_tag_d = p_tag;
        p_ct_d  = p_ct;
        hold_d  = hold_ctr;
        load_o  = 1'b0;
        in_a    = 1'b0;

        unique case (state)
            EMPTY:   in_a = 1'b1;
            ACCUM:   in_a = merge || o_free;
            default: in_a = 1'b0;
        endcase
        if (!reset) in_a = 1'b0;
        accept = in_v && in_a;

        unique case (state)
            EMPTY: begin
                if (accept && in_ct != '0) begin
                    p_tag_d = in_tag;
                    p_ct_d  = in_ct;
                    hold_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Zero-count events are swallowed without touching the pending entry.
                    if (in_ct != '0) begin
                        if (merge) begin
                            p_ct_d = sum[Nct-1:0];
                        end else begin
                            load_o  = 1'b1;
                            p_tag_d = in_tag;
                            p_ct_d  = in_ct;
                            hold_d  = '0;
                        end
                    end
                end else if (hold_ctr == HOLD_LAST) begin
                    if (o_free) begin
                        load_o  = 1'b1;
                        state_d = EMPTY;
                    end
                end else begin
                    hold_d = hold_ctr + 1'b1;
                end
            end
            default: begin
                if (o_free) begin
                    load_o  = 1'b1;
                    state_d = EMPTY;
                end
            end
        endcase

        if (unit_pulse && state_d != EMPTY) state_d = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: payload registers are reset as well, since out_tag/out_ct must read zero after reset.
            state    <= EMPTY;
            p_tag    <= '0;
            p_ct     <= '0;
            hold_ctr <= '0;
            out_v    <= 1'b0;
            out_tag  <= '0;
            out_ct   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state    <= state_d;
            p_tag    <= p_tag_d;
            p_ct     <= p_ct_d;
            hold_ctr <= hold_d;
            if (o_free) begin
                out_v <= load_o;
                if (load_o) begin
                    out_tag <= p_tag;
                    out_ct  <= p_ct;
                end
            end
        end
    end
endmodule

// File: tb/tb_tag_ct_coalescer.sv
// Self-checking bench for tag_ct_coalescer: directed scenarios plus a randomized
// back-pressure run, all compared every cycle against a transaction-level model.
module tb_tag_ct_coalescer;
    localparam int NTAG    = 11;
    localparam int NCT     = 10;
    localparam int MAXHOLD = 64;
    localparam int CT_MAX  = (1 << NCT) - 1;

    logic            clk, reset, unit_pulse, coalesce_en;
    logic            in_v, in_a, out_v, out_a;
    logic [NTAG-1:0] in_tag, out_tag;
    logic [NCT-1:0]  in_ct, out_ct;

    tag_ct_coalescer #(.Ntag(NTAG), .Nct(NCT), .MaxHold(MAXHOLD)) dut (
        .clk(clk), .reset(reset), .unit_pulse(unit_pulse), .coalesce_en(coalesce_en),
        .in_v(in_v), .in_tag(in_tag), .in_ct(in_ct), .in_a(in_a),
        .out_v(out_v), .out_tag(out_tag), .out_ct(out_ct), .out_a(out_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: pending group and output slot described with the spec's own quantities.
    typedef struct {
        bit pv;   int tag;  int ct;  int hold;  bit fp;
        bit ov;   int otag; int oct;
    } model_t;

    function automatic bit model_merge(model_t m, bit cen, int tag, int ct);
        return cen && m.pv && (tag == m.tag) && (m.ct + ct <= CT_MAX);
    endfunction

    function automatic bit model_ina(model_t m, bit rst_n, bit cen, int tag, int ct, bit oa);
        if (!rst_n) return 1'b0;
        if (!m.pv)  return 1'b1;
        if (m.fp)   return 1'b0;
        return model_merge(m, cen, tag, ct) || !m.ov || oa;
    endfunction

    function automatic model_t model_next(model_t m, bit rst_n, bit up, bit cen, bit v,
                                          int tag, int ct, bit oa);
        model_t n = m;
        bit free = !m.ov || oa;
        bit emit = 1'b0;
        bit flushed = 1'b0;
        bit acc;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        acc = v && model_ina(m, rst_n, cen, tag, ct, oa);
        if (!m.pv) begin
            if (acc && ct != 0) begin
                n.pv = 1'b1; n.tag = tag; n.ct = ct; n.hold = 0;
            end
        end else if (m.fp) begin
            if (free) begin emit = 1'b1; n.pv = 1'b0; flushed = 1'b1; end
        end else if (acc) begin
            if (ct != 0) begin
                if (model_merge(m, cen, tag, ct)) n.ct = m.ct + ct;
                else begin emit = 1'b1; n.tag = tag; n.ct = ct; n.hold = 0; end
            end
        end else if (m.hold >= MAXHOLD - 1) begin
            if (free) begin emit = 1'b1; n.pv = 1'b0; end
        end else begin
            n.hold = m.hold + 1;
        end
        n.fp = up || (m.fp && m.pv && !flushed);
        if (free) begin
            n.ov = emit;
            if (emit) begin n.otag = m.tag; n.oct = m.ct; end
        end
        return n;
    endfunction

    typedef struct { int tag; int ct; } ev_t;

    model_t     m;
    ev_t        got_q[$];
    bit         started;
    bit         hold_chk;
    logic [NTAG-1:0] held_tag;
    logic [NCT-1:0]  held_ct;
    int         cyc = 0;

    always @(posedge clk) begin
        m        <= model_next(m, reset, unit_pulse, coalesce_en, in_v, int'(in_tag), int'(in_ct), out_a);
        started  <= 1'b1;
        cyc      <= cyc + 1;
        hold_chk <= reset && out_v && !out_a;
        held_tag <= out_tag;
        held_ct  <= out_ct;
        if (reset && out_v && out_a) got_q.push_back('{int'(out_tag), int'(out_ct)});
    end

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            check("in_a", 32'(in_a), 32'(model_ina(m, reset, coalesce_en, int'(in_tag), int'(in_ct), out_a)));
            check("out_v", 32'(out_v), 32'(m.ov));
            if (m.ov) begin
                check("out_tag", 32'(out_tag), m.otag);
                check("out_ct", 32'(out_ct), m.oct);
            end
            if (hold_chk) begin
                check("stall_out_v", 32'(out_v), 32'd1);
                check("stall_tag", 32'(out_tag), 32'(held_tag));
                check("stall_ct", 32'(out_ct), 32'(held_ct));
            end
        end
    end

    int last_acc_cyc;

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse();
        unit_pulse = 1'b1;
        @(posedge clk); #1;
        unit_pulse = 1'b0;
    endtask

    task automatic send(input int tag, input int ct);
        bit ok = 1'b0;
        int n = 0;
        in_v   = 1'b1;
        in_tag = NTAG'(tag);
        in_ct  = NCT'(ct);
        while (!ok && n < 500) begin
            @(negedge clk); ok = in_a;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("send_accept", 32'(ok), 32'd1);
        last_acc_cyc = cyc;
        in_v = 1'b0;
    endtask

    task automatic expect_ev(input string name, input int idx, input int tag, input int ct);
        check({name, "_tag"}, got_q[idx].tag, tag);
        check({name, "_ct"}, got_q[idx].ct, ct);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    int  base, a_cyc, b_cyc, wait_n, s;
    int  in_sum[4];
    bit  rand_active;

    initial begin
        reset = 1'b0; unit_pulse = 1'b0; coalesce_en = 1'b1; out_a = 1'b1;
        in_v = 1'b1; in_tag = NTAG'(3); in_ct = NCT'(1);

        // 1: reset held with valid input offered
        repeat (3) begin
            @(posedge clk); #1;
            check("t1_in_a_reset", 32'(in_a), 32'd0);
            check("t1_out_v_reset", 32'(out_v), 32'd0);
        end
        check("t1_out_tag_reset", 32'(out_tag), 32'd0);
        check("t1_out_ct_reset", 32'(out_ct), 32'd0);
        in_v = 1'b0; reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("t1_out_v_after", 32'(out_v), 32'd0);
        end

        // 2: merge of three same-tag events, successor held until the pulse
        base = got_q.size();
        repeat (3) send(512, 1);
        send(513, 1);
        idle(5);
        check("t2_count_before", got_q.size() - base, 1);
        expect_ev("t2_first", base, 512, 3);
        pulse(); idle(4);
        check("t2_count_after", got_q.size() - base, 2);
        expect_ev("t2_second", base + 1, 513, 1);

        // 3: saturation refuses the merge instead of wrapping
        base = got_q.size();
        send(7, 1000); send(7, 30);
        idle(4);
        check("t3_count_before", got_q.size() - base, 1);
        expect_ev("t3_first", base, 7, 1000);
        pulse(); idle(4);
        check("t3_count_after", got_q.size() - base, 2);
        expect_ev("t3_second", base + 1, 7, 30);

        // 4: pass-through mode never merges
        coalesce_en = 1'b0;
        base = got_q.size();
        repeat (4) send(9, 1);
        pulse(); idle(4);
        check("t4_count", got_q.size() - base, 4);
        for (int i = 0; i < 4; i++) expect_ev($sformatf("t4_ev%0d", i), base + i, 9, 1);
        coalesce_en = 1'b1;

        // 6: hold timeout with no unit_pulse
        base = got_q.size();
        send(5, 2);
        a_cyc = last_acc_cyc;
        wait_n = 0;
        do begin
            @(negedge clk); wait_n++;
        end while (!out_v && wait_n < 200);
        b_cyc = cyc;
        check("t6_latency", b_cyc - a_cyc, MAXHOLD);
        check("t6_tag", 32'(out_tag), 32'd5);
        check("t6_ct", 32'(out_ct), 32'd2);
        idle(3);

        // 7: reset with pending slot and output register both occupied
        out_a = 1'b0;
        send(20, 5); send(21, 6);
        idle(2);
        check("t7_out_v_full", 32'(out_v), 32'd1);
        reset = 1'b0; idle(2); reset = 1'b1; out_a = 1'b1;
        base = got_q.size();
        idle(10);
        check("t7_no_output", got_q.size() - base, 0);
        send(22, 4); pulse(); idle(4);
        check("t7_count_after", got_q.size() - base, 1);
        expect_ev("t7_next", base, 22, 4);

        // 5: randomized traffic under random back-pressure and pulses
        base = got_q.size();
        for (int k = 0; k < 4; k++) in_sum[k] = 0;
        rand_active = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int t, c;
                    t = int'($urandom_range(0, 3));
                    c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 600));
                    coalesce_en = ($urandom_range(0, 7) != 0);
                    in_sum[t] += c;
                    send(100 + t, c);
                    idle(int'($urandom_range(0, 2)));
                end
                rand_active = 1'b0;
            end
            begin
                while (rand_active) begin
                    out_a = 1'b0;
                    idle(int'($urandom_range(0, 10)));
                    out_a = 1'b1;
                    idle(int'($urandom_range(1, 3)));
                end
                out_a = 1'b1;
            end
            begin
                while (rand_active) begin
                    unit_pulse = ($urandom_range(0, 24) == 0);
                    @(posedge clk); #1;
                end
                unit_pulse = 1'b0;
            end
        join
        coalesce_en = 1'b1;
        out_a = 1'b1;
        pulse(); idle(10);
        for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int j = base; j < got_q.size(); j++)
                if (got_q[j].tag == 100 + k) s += got_q[j].ct;
            check($sformatf("t5_sum_tag%0d", 100 + k), s, in_sum[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
